median_window_col_gen: RTL and testbench
========================================

// Module: median_window_col_gen
// PURPOSE
//  Streaming upstream stage of the 3x3 median filter. Accepts raster-scan 8-bit pixels and emits one
//  vertical 3-pixel column (rows y-2, y-1, y at column x) per accepted pixel. Its outputs feed the
//  3-input max/med/min sorter directly. Two on-chip line buffers hold the previous two image rows.
// PARAMETERS
//  IMG_W   640  pixels per row (>=3); sets line-buffer depth and x-counter wrap
//  IMG_H   480  rows per frame (>=3); sets y-counter wrap
//  PIX_W   8    bits per pixel
// PORTS
//  clk        in   1              rising-edge clock, single clock domain
//  rst_n      in   1              synchronous reset, active-low
//  in_valid   in   1              in_pixel valid this cycle
//  in_ready   out  1              block can accept in_pixel; transfer when in_valid & in_ready
//  in_pixel   in   PIX_W          raster-order pixel, row 0 col 0 first
//  out_valid  out  1              col_* valid
//  out_ready  in   1              downstream accepts; transfer when out_valid & out_ready
//  col_top    out  PIX_W          pixel (x, y-2)
//  col_mid    out  PIX_W          pixel (x, y-1)
//  col_bot    out  PIX_W          pixel (x, y)
//  out_sol    out  1              column is x==0 of an emitted row
//  out_eof    out  1              column is last of frame (x==IMG_W-1, y==IMG_H-1)
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): x_cnt=0, y_cnt=0, out_valid=0, col_*=0, out_sol=0, out_eof=0.
//    Line-buffer contents not cleared; never observable (see row rules). Reset mid-frame discards
//    partial frame; next accepted pixel is treated as (0,0).
//  - in_ready = out_ready | ~out_valid (combinational; one output register, no skid buffer).
//  - On input transfer: read lb1[x], lb0[x] (read-before-write); write lb0[x]<=lb1[x], lb1[x]<=in_pixel.
//    Output register loads {lb0[x], lb1[x], in_pixel} next edge -> latency exactly 1 cycle.
//  - Output transfer without new input: out_valid->0. Simultaneous in+out transfer: out_valid stays 1.
//  - out_valid held with stable col_*/flags while out_ready==0.
//  - Counters: x_cnt increments per input transfer, wraps IMG_W-1->0 with y_cnt++; at
//    (IMG_W-1, IMG_H-1) both wrap to 0 (next frame, no gap cycles required).
//  - Rows 0 and 1: handling per CONFIGURATION. out_eof asserted with last column of frame only.
//  - Widths: counters $clog2(IMG_W), $clog2(IMG_H) bits; no arithmetic on pixel data.
// CONFIGURATION
//  MEDIAN_BORDER_REPLICATE_EN
//   defined:   every input produces an output (IMG_W*IMG_H columns/frame). Row 0 emits {p,p,p};
//              row 1 emits {r0,r0,p} where r0 = lb1[x]. out_sol on x==0 of every row.
//   undefined: rows 0,1 write line buffers but emit nothing (out_valid not set); only rows>=2
//              emit, IMG_W*(IMG_H-2) columns/frame. out_sol on x==0 of rows>=2.
// STRUCTURE
//  - Package median_pkg: PIX_W localparam, typedef pixel_t [PIX_W-1:0], typedef struct column_t
//    {top, mid, bot}; shared with sorter and later median stages.
//  - Sub-module median_line_buf (depth IMG_W, width PIX_W, 1 read + 1 write same address,
//    read-before-write); instantiated twice (lb0, lb1).
//  - Top holds counters, output register, handshake logic.
// TESTING  (bench IMG_W=4, IMG_H=4, pixel value = 16*y + x)
//  1 Full frame, out_ready=1, no define: 8 columns; first (x0,y2) = {0x00,0x10,0x20},
//    last (x3,y3) = {0x13,0x23,0x33} with out_eof=1; out_sol on 0x20 and 0x30 columns.
//  2 Same frame, MEDIAN_BORDER_REPLICATE_EN: 16 columns; (x2,y0)={02,02,02}, (x2,y1)={02,02,12}.
//  3 Backpressure: out_ready=0 for 5 cycles mid-row 2 -> in_ready=0, col_* stable, no pixel lost;
//    column sequence identical to test 1.
//  4 in_valid gaps (random 50%) -> output sequence identical to test 1; latency 1 cycle per column.
//  5 rst_n=0 one cycle after pixel (1,2) -> out_valid=0; restart frame -> outputs match test 1
//    from the (0,2) column onward.
//  6 Two back-to-back frames -> second frame output equals first; out_eof exactly once per frame.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types for the 3x3 median filter pipeline (column generator, sorter, later stages).
package median_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } column_t;

    function automatic column_t make_column(input pixel_t top, input pixel_t mid, input pixel_t bot);
        column_t c;
        c.top = top;
        c.mid = mid;
        c.bot = bot;
        return c;
    endfunction

endpackage

// File: rtl/median_window_col_gen_if.sv
// Pixel-in / column-out stream bundle of the median column generator.
interface median_window_col_gen_if;
    import median_pkg::*;

    logic   in_valid;
    logic   in_ready;
    pixel_t in_pixel;
    logic   out_valid;
    logic   out_ready;
    pixel_t col_top;
    pixel_t col_mid;
    pixel_t col_bot;
    logic   out_sol;
    logic   out_eof;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, col_top, col_mid, col_bot, out_sol, out_eof
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, col_top, col_mid, col_bot, out_sol, out_eof
    );

endinterface

// File: rtl/median_line_buf.sv
// One image row of pixel storage; single shared address, asynchronous read-before-write.
module median_line_buf
    import median_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  pixel_t        wr_data,
    output pixel_t        rd_data
);

    pixel_t mem_r [DEPTH];

    // Old contents are visible combinationally during the cycle that overwrites them.
    assign rd_data = mem_r[addr];

    // Row storage write; contents are never reset since stale rows are never emitted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_col_gen.sv
// Raster pixel stream -> vertical 3-pixel columns for the median sorter.
// Optional MEDIAN_BORDER_REPLICATE_EN: emit rows 0/1 with replicated top rows instead of dropping them.
module median_window_col_gen
    import median_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    median_window_col_gen_if.slave  bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(2);

    logic [XW-1:0] x_cnt_r;
    logic [YW-1:0] y_cnt_r;
    logic          out_valid_r;
    column_t       col_r;
    logic          sol_r;
    logic          eof_r;

    logic          in_fire_s;
    logic          out_fire_s;
    logic          emit_s;
    column_t       col_next_s;
    pixel_t        lb0_rd_s;
    pixel_t        lb1_rd_s;

    // lb1 holds row y-1 and lb0 row y-2; each accepted pixel shifts its column down one row.
    median_line_buf #(.DEPTH(IMG_W), .AW(XW)) u_lb0 (
        .clk     (clk),
        .wr_en   (in_fire_s),
        .addr    (x_cnt_r),
        .wr_data (lb1_rd_s),
        .rd_data (lb0_rd_s)
    );

    median_line_buf #(.DEPTH(IMG_W), .AW(XW)) u_lb1 (
        .clk     (clk),
        .wr_en   (in_fire_s),
        .addr    (x_cnt_r),
        .wr_data (bus.in_pixel),
        .rd_data (lb1_rd_s)
    );

    assign bus.in_ready = bus.out_ready | ~out_valid_r;
    assign in_fire_s    = bus.in_valid & bus.in_ready;
    assign out_fire_s   = out_valid_r & bus.out_ready;

    // Decide whether the current row emits and build the column it would emit.
    always_comb begin
        emit_s     = 1'b0;
        col_next_s = make_column(lb0_rd_s, lb1_rd_s, bus.in_pixel);
`ifdef MEDIAN_BORDER_REPLICATE_EN
        emit_s = 1'b1;
        if (y_cnt_r == YW'(0)) begin
            col_next_s = make_column(bus.in_pixel, bus.in_pixel, bus.in_pixel);
        end else if (y_cnt_r == YW'(1)) begin
            col_next_s = make_column(lb1_rd_s, lb1_rd_s, bus.in_pixel);
        end else begin
            col_next_s = make_column(lb0_rd_s, lb1_rd_s, bus.in_pixel);
        end
`else
        if (y_cnt_r >= Y_FIRST) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
`endif
    end

    // Raster counters, single output register and its valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt_r     <= {XW{1'b0}};
            y_cnt_r     <= {YW{1'b0}};
            out_valid_r <= 1'b0;
            col_r       <= make_column({PIX_W{1'b0}}, {PIX_W{1'b0}}, {PIX_W{1'b0}});
            sol_r       <= 1'b0;
            eof_r       <= 1'b0;
        end else begin
            if (in_fire_s) begin
                if (x_cnt_r == X_LAST) begin
                    x_cnt_r <= {XW{1'b0}};
                    y_cnt_r <= (y_cnt_r == Y_LAST) ? {YW{1'b0}} : y_cnt_r + YW'(1);
                end else begin
                    x_cnt_r <= x_cnt_r + XW'(1);
                end
            end
            if (in_fire_s && emit_s) begin
                out_valid_r <= 1'b1;
                col_r       <= col_next_s;
                sol_r       <= (x_cnt_r == {XW{1'b0}});
                eof_r       <= (x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST);
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.col_top   = col_r.top;
    assign bus.col_mid   = col_r.mid;
    assign bus.col_bot   = col_r.bot;
    assign bus.out_sol   = sol_r;
    assign bus.out_eof   = eof_r;

endmodule

// File: tb/tb_median_window_col_gen.sv
// Bench for median_window_col_gen on a 4x4 image with pixel = 16*y + x.
module tb_median_window_col_gen;
    import median_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_window_col_gen_if bus();

    median_window_col_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: image rows by position ----------------
    logic [7:0]  img [H][W];
    int          acc_idx = 0;
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    logic [25:0] ref1[$];
    int          eof_seen = 0;
    int          stall_cycles = 0;

    function automatic logic row_emits(input int y);
`ifdef MEDIAN_BORDER_REPLICATE_EN
        return 1'b1;
`else
        return (y >= 2);
`endif
    endfunction

    // Column = {sol, eof, top, mid, bot}
    function automatic logic [25:0] model_col(input int x, input int y, input logic [7:0] p);
        logic [7:0] t;
        logic [7:0] m;
        if (y == 0) begin
            t = p; m = p;
        end else if (y == 1) begin
            t = img[0][x]; m = img[0][x];
        end else begin
            t = img[y-2][x]; m = img[y-1][x];
        end
        return {(x == 0), (x == W-1 && y == H-1), t, m, p};
    endfunction

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_in_emit = 1'b0;
    logic [25:0] prev_out = 26'd0;
    logic [25:0] cur;
    logic        in_emit;

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        cur = {bus.out_sol, bus.out_eof, bus.col_top, bus.col_mid, bus.col_bot};
        if (!rst_n) begin
            exp_q.delete();
            acc_idx      = 0;
            prev_valid   = 1'b0;
            prev_ready   = 1'b0;
            prev_in_emit = 1'b0;
        end else begin
            if (prev_in_emit) check("valid_after_accept", bus.out_valid, 1);
            if (bus.out_valid && !(prev_valid && !prev_ready)) check("new_col_latency1", prev_in_emit, 1);
            if (prev_valid && !prev_ready) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", cur, prev_out);
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", bus.in_ready, 0);
                stall_cycles++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("col_expected_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("col", cur, exp_q.pop_front());
                got_q.push_back(cur);
                if (bus.out_eof) eof_seen++;
            end
            in_emit = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                int x, y;
                x = acc_idx % W;
                y = acc_idx / W;
                if (row_emits(y)) begin
                    exp_q.push_back(model_col(x, y, bus.in_pixel));
                    in_emit = 1'b1;
                end
                img[y][x] = bus.in_pixel;
                acc_idx = (acc_idx + 1) % (W * H);
            end
            prev_valid   = bus.out_valid;
            prev_ready   = bus.out_ready;
            prev_out     = cur;
            prev_in_emit = in_emit;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_pixel(input logic [7:0] p);
        logic ok;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("in_ready_timeout", ok, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int gaps;
                gaps = 0;
                while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct && gaps < 8) begin
                    @(posedge clk); #1;
                    gaps++;
                end
                send_pixel(8'(16 * y + x));
            end
        end
    endtask

    task automatic drain();
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cmp_seq(input string name, input int copies);
        check({name, "_count"}, got_q.size(), ref1.size() * copies);
        for (int c = 0; c < copies; c++) begin
            for (int i = 0; i < ref1.size(); i++) begin
                if (c * ref1.size() + i < got_q.size())
                    check(name, got_q[c * ref1.size() + i], ref1[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = 8'h00;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_col", {bus.col_top, bus.col_mid, bus.col_bot}, 0);
        check("rst_flags", {bus.out_sol, bus.out_eof}, 0);
        rst_n = 1'b1;

        // Baseline frame with literal pins on the model
        got_q.delete();
        send_frame(0);
        drain();
`ifdef MEDIAN_BORDER_REPLICATE_EN
        check("t2_count", got_q.size(), 16);
        if (got_q.size() >= 16) begin
            check("t2_first", got_q[0], {1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
            check("t2_x2y0", got_q[2], {1'b0, 1'b0, 8'h02, 8'h02, 8'h02});
            check("t2_x2y1", got_q[6], {1'b0, 1'b0, 8'h02, 8'h02, 8'h12});
            check("t2_last", got_q[15], {1'b0, 1'b1, 8'h13, 8'h23, 8'h33});
        end
`else
        check("t1_count", got_q.size(), 8);
        if (got_q.size() >= 8) begin
            check("t1_first", got_q[0], {1'b1, 1'b0, 8'h00, 8'h10, 8'h20});
            check("t1_x1y2", got_q[1], {1'b0, 1'b0, 8'h01, 8'h11, 8'h21});
            check("t1_sol_row3", got_q[4], {1'b1, 1'b0, 8'h10, 8'h20, 8'h30});
            check("t1_last", got_q[7], {1'b0, 1'b1, 8'h13, 8'h23, 8'h33});
        end
`endif
        ref1 = got_q;

        // Backpressure for 5 cycles once row 2 has started
        got_q.delete();
        stall_cycles = 0;
        fork
            send_frame(0);
            begin
                repeat (9) begin
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t3_stall_cycles", stall_cycles, 5);
        cmp_seq("t3_seq", 1);

        // Random input gaps
        got_q.delete();
        send_frame(50);
        drain();
        cmp_seq("t4_seq", 1);

        // Reset one cycle after pixel (1,2), then a clean frame
        for (int i = 0; i < 10; i++) send_pixel(8'(16 * (i / W) + (i % W)));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_flags", {bus.out_sol, bus.out_eof}, 0);
        rst_n = 1'b1;
        got_q.delete();
        send_frame(0);
        drain();
        cmp_seq("t5_seq", 1);

        // Two back-to-back frames
        got_q.delete();
        eof_seen = 0;
        send_frame(0);
        send_frame(0);
        drain();
        check("t6_eof_count", eof_seen, 2);
        cmp_seq("t6_seq", 2);
        check("t6_model_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
